data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving storage size in 32-bit words (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving wait states inserted per access (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address from ALU result.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have port req_be, input, 4 bits: byte enables for stores; bit i enables byte [8i+7:8i].
REQ-011 The block SHALL have port resp_valid, output, 1 bit: response available.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit: access was misaligned or out of range.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; write, addr, wdata and be SHALL be latched on that edge.
REQ-018 On accept, the FSM SHALL enter WAIT with wait counter = WAIT_CYCLES; if WAIT_CYCLES = 0 it SHALL enter RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle; on the edge where it is 1, the FSM SHALL enter RESP; WAIT SHALL last exactly WAIT_CYCLES cycles.
REQ-020 The memory access SHALL be performed on the edge entering RESP: store bytes committed, load word registered into resp_rdata.
REQ-021 Latency: accept at edge N -> resp_valid high after edge N+WAIT_CYCLES+1.
REQ-022 In RESP, resp_rdata and resp_err SHALL hold stable until resp_ready = 1; on that edge the FSM SHALL return to IDLE and resp_valid SHALL drop.
REQ-023 Back-to-back requests: the next request SHALL NOT be accepted before the cycle after the response handshake.
REQ-024 Word index SHALL be req_addr[31:2]; req_addr[1:0] != 0 or index >= DEPTH SHALL set resp_err = 1, leave memory unchanged, and return resp_rdata = 0.
REQ-025 Stores SHALL write only enabled bytes; req_be = 0 SHALL be a successful no-op (resp_err = 0); loads SHALL ignore req_be and return the full word.
REQ-026 Store responses SHALL return resp_rdata = 0.
REQ-027 req_valid while not in IDLE SHALL be ignored and SHALL have no effect on state.

Reset
REQ-028 While rst = 1, state SHALL go to IDLE, counter to 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready and busy SHALL read 0 in the reset cycle and 1 and 0 respectively after it.
REQ-029 Memory contents SHALL NOT be cleared by reset; they SHALL be zero at time 0.
REQ-030 Reset in WAIT SHALL drop the pending request with no memory write; reset in RESP SHALL drop the response.

Verification (DEPTH=256, WAIT_CYCLES=2)
REQ-031 Store addr 0x10, wdata 0xDEADBEEF, be 0xF accepted at edge N -> resp_valid at N+3, resp_err 0, resp_rdata 0; a later load of 0x10 returns 0xDEADBEEF.
REQ-032 Store addr 0x10, wdata 0x11223344, be 0x5 over 0xDEADBEEF -> a later load returns 0xDE22BE44.
REQ-033 Load addr 0x12 -> resp_err 1, rdata 0; store addr 0x400 -> resp_err 1, and a load of 0x0 is unchanged.
REQ-034 Hold resp_ready 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready 0 throughout; the handshake then returns to IDLE in 1 cycle.
REQ-035 Assert rst one cycle after accepting a store to 0x20 -> no write; a load of 0x20 returns the prior value; resp_valid stays 0 until a new request.
REQ-036 Rebuild with WAIT_CYCLES = 0 -> load accepted at edge N gives resp_valid after edge N+1.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Latency: accept at edge N, resp_valid high after edge N+WAIT_CYCLES+1.
// Backpressure: one access in flight; req_ready low until the response handshake.
module data_mem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    wait_cnt;

   // Request fields captured on the accept edge
   logic          lat_write;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_be;

   // Operands of the access actually performed this edge
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic          accept;
   logic          access_fire;

   // Storage is not touched by reset; it powers up cleared
   logic [31:0]   mem [DEPTH] = '{default: '0};

   assign req_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);
   assign accept    = req_valid && req_ready;

   // With zero wait states the access happens on the accept edge itself,
   // so the live request is used; otherwise the captured copy is used.
   always_comb begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      if (state == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end
   end

   // Misaligned or beyond the last word -> error, no memory side effect
   assign acc_err     = (|acc_addr[1:0]) || (|acc_addr[31:AW+2]);
   assign acc_idx     = acc_addr[AW+1:2];
   assign access_fire = !rst &&
                        (((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (wait_cnt == 4'd1)));

   // Byte-enabled store commit on the edge entering RESP
   always_ff @(posedge clk) begin
      if (access_fire && acc_write && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // Control FSM; the response register is loaded on entry to RESP and
   // resp_valid follows one edge later, so the response is presented
   // from a settled register stage for the whole time it is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_LD;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
               end else if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (access_fire) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one 2-wait-state instance and one
// zero-wait instance sharing the request payload and clock.
// Expected responses are queued at drive time and popped on resp_valid.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_valid0;
   logic        req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_ready;

   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;
   logic        req_ready0, resp_valid0, resp_err0, busy0;
   logic [31:0] resp_rdata0;

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid0), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction. sel=1 targets the zero-wait instance.
   // stray keeps req_valid high with a different store while busy.
   task automatic access(input bit sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int hold, input bit stray);
      exp_t e;
      int   n;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);

      @(negedge clk);
      req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
      if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
      n = 0;
      while (!(sel ? req_ready0 : req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_accept", 32'(sel ? req_ready0 : req_ready), 32'd1);

      @(posedge clk);
      #1;
      if (stray) begin
         req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
      end else begin
         req_valid = 1'b0; req_valid0 = 1'b0;
      end

      n = 0;
      while (!(sel ? resp_valid0 : resp_valid) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0; req_valid0 = 1'b0;
      check("latency", 32'(n), sel ? 32'd1 : 32'd3);
      check("sb_occupancy", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("rdata", sel ? resp_rdata0 : resp_rdata, e.rdata);
         check("err", 32'(sel ? resp_err0 : resp_err), 32'(e.err));
      end

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, exp_rdata);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_busy", 32'(busy), 32'd1);
      end

      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("post_hs_valid", 32'(sel ? resp_valid0 : resp_valid), 32'd0);
      check("post_hs_ready", 32'(sel ? req_ready0 : req_ready), 32'd1);
      check("post_hs_busy", 32'(sel ? busy0 : busy), 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0; resp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("after_rst_req_ready", 32'(req_ready), 32'd1);
      check("after_rst_busy", 32'(busy), 32'd0);

      // Full store, full and partial reload
      access(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0);
      access(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 0);
      access(0, 1, 32'h10, 32'h1122_3344, 4'h5, 32'h0, 0, 0, 0);
      access(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 0, 0, 0);
      // Errors: misaligned, out of range, high address bits
      access(0, 0, 32'h12, 32'h0, 4'hF, 32'h0, 1, 0, 0);
      access(0, 1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 1);
      access(0, 1, 32'h8000_0010, 32'h0BAD_0BAD, 4'hF, 32'h0, 1, 0, 0);
      access(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 0);
      // Backpressure on the response
      access(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 0, 5, 0);
      // Empty byte mask is a successful no-op
      access(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 0, 0);
      access(0, 0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 0, 0, 0);
      // Last word in range
      access(0, 1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, 32'h0, 0, 0, 0);
      access(0, 0, 32'h3FC, 32'h0, 4'h0, 32'hA5A5_5A5A, 0, 0, 0);

      // Reset while a store is waiting drops it
      access(0, 1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0, 0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h1234_5678; req_be = 4'hF;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(resp_valid), 32'd0);
         check("post_rst_ready", 32'(req_ready), 32'd1);
      end
      access(0, 0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, 0);

      // Zero-wait instance
      access(1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 0, 0, 0);
      access(1, 1, 32'h40, 32'h7788_99AA, 4'hC, 32'h0, 0, 0, 0);
      access(1, 0, 32'h40, 32'h0, 4'h0, 32'h7788_0000, 0, 0, 0);
      access(1, 0, 32'h41, 32'h0, 4'h0, 32'h0, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
